// File: rtl/led_driver.sv
// Scanning driver for a 3-digit common-anode 7-segment display.
// Ports: clock, reset (async high), x0..x2 hex in, seg[6:0]/an[2:0] active-low out.
// Optional leading-zero blanking: define LED_DRIVER_LZB_EN.
module led_driver #(
  parameter int DIV_WIDTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt;
  logic [1:0]           dig;
  logic [1:0]           dig_nxt;
  logic [2:0]           an_nxt;
  logic [6:0]           seg_nxt;
  logic [3:0]           val;
  logic                 blank;

  // Active-low hex decode, bits {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State register: prescaler, digit index and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dig <= 2'd0;
      an  <= 3'b111;
      seg <= 7'h7F;
    end else begin
      cnt <= cnt + CNT_ONE;
      dig <= dig_nxt;
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  // Next digit: advance at the end of each dwell; recover from 3.
  always_comb begin
    dig_nxt = dig;
    if (dig == 2'd3) begin
      dig_nxt = 2'd0;
    end else if (&cnt) begin
      dig_nxt = (dig == 2'd2) ? 2'd0 : dig + 2'd1;
    end
  end

  // Output decode from the pre-edge digit and live inputs.
  always_comb begin
    an_nxt = 3'b111;
    val    = x0;
    blank  = 1'b1;
    case (dig)
      2'd0: begin
        an_nxt = 3'b110;
        val    = x0;
        blank  = 1'b0;
      end
      2'd1: begin
        an_nxt = 3'b101;
        val    = x1;
`ifdef LED_DRIVER_LZB_EN
        blank  = (x2 == 4'h0) && (x1 == 4'h0);
`else
        blank  = 1'b0;
`endif
      end
      2'd2: begin
        an_nxt = 3'b011;
        val    = x2;
`ifdef LED_DRIVER_LZB_EN
        blank  = (x2 == 4'h0);
`else
        blank  = 1'b0;
`endif
      end
      default: begin
        an_nxt = 3'b111;
        val    = x0;
        blank  = 1'b1;
      end
    endcase
    seg_nxt = blank ? 7'h7F : dec(val);
  end

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver: randomized stimulus checked every edge against
// an edge-count model of the scan, plus literal pins of key points.
module tb_led_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] x0 = 4'h0;
  logic [3:0] x1 = 4'h0;
  logic [3:0] x2 = 4'h0;
  logic [6:0] seg;
  logic [2:0] an;

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic [6:0] dec_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  led_driver #(.DIV_WIDTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .x0(x0),
    .x1(x1),
    .x2(x2),
    .seg(seg),
    .an(an)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [9:0] act,
                     input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d an/seg got %b/%h want %b/%h", name, n,
               act[9:7], act[6:0], req[9:7], req[6:0]);
    end
  endtask

  // Model: edge n (1-based since release) shows digit ((n-1)/16) mod 3.
  function automatic logic [6:0] model_seg(input int d);
    logic [3:0] v;
    v = (d == 0) ? x0 : (d == 1) ? x1 : x2;
`ifdef LED_DRIVER_LZB_EN
    if (d == 2 && x2 == 4'h0) return 7'h7F;
    if (d == 1 && x2 == 4'h0 && x1 == 4'h0) return 7'h7F;
`endif
    return dec_tab[v];
  endfunction

  task automatic tick();
    logic [2:0] ea;
    logic [6:0] es;
    int d;
    @(posedge clock);
    if (reset) begin
      n  = 0;
      ea = 3'b111;
      es = 7'h7F;
    end else begin
      n++;
      d  = ((n - 1) / 16) % 3;
      ea = ~(3'b001 << d);
      es = model_seg(d);
    end
    #1;
    chk("scan", {an, seg}, {ea, es});
  endtask

  initial begin
    x0 = 4'h8;
    x1 = 4'h0;
    x2 = 4'h1;
    #1 reset = 1'b1;
    #2;
    chk("reset_noclk", {an, seg}, {3'b111, 7'h7F});
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 64; i++) begin
      tick();
      if (n == 1)  chk("edge1",  {an, seg}, {3'b110, 7'h00});
      if (n == 16) chk("edge16", {an, seg}, {3'b110, 7'h00});
      if (n == 17) chk("edge17", {an, seg}, {3'b101, 7'h40});
      if (n == 33) chk("edge33", {an, seg}, {3'b011, 7'h79});
      if (n == 48) chk("edge48", {an, seg}, {3'b011, 7'h79});
      if (n == 49) chk("edge49", {an, seg}, {3'b110, 7'h00});
    end

    while (n < 96) tick();
    tick();
    x0 = 4'hF;
    tick();
    chk("x0_to_F", {an, seg}, {3'b110, 7'h0E});

    while (n < 112) tick();
    for (int i = 0; i < 32; i++) begin
      x0 = 4'($urandom_range(0, 15));
      tick();
    end
    chk("x0_ignored", {an, seg}, {3'b011, 7'h79});

    for (int v = 0; v < 16; v++) begin
      x0 = 4'(v);
      tick();
    end
    chk("sweep_F", {an, seg}, {3'b110, 7'h0E});

    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    chk("reset_async", {an, seg}, {3'b111, 7'h7F});
    tick();
    tick();
    reset = 1'b0;
    x0 = 4'h3;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("restart_d0", {an, seg}, {3'b110, 7'h30});
    end
    tick();
    chk("restart_d1", {an, seg}, {3'b101, 7'h40});

    x2 = 4'h0;
    x1 = 4'h0;
    x0 = 4'h5;
    while (n < 48) tick();
`ifdef LED_DRIVER_LZB_EN
    chk("lzb_d2", {an, seg}, {3'b011, 7'h7F});
`else
    chk("nolzb_d2", {an, seg}, {3'b011, 7'h40});
`endif
    for (int i = 0; i < 48; i++) tick();

    for (int i = 0; i < 800; i++) begin
      x0 = 4'($urandom_range(0, 15));
      x1 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      x2 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        chk("rand_reset", {an, seg}, {3'b111, 7'h7F});
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
